// File: rtl/smem_fill_pkg.sv
// smem_fill_pkg: shared state encoding and register map for the screen fill engine
package smem_fill_pkg;
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
    localparam logic [1:0] OFF_START = 2'd0;
    localparam logic [1:0] OFF_COUNT = 2'd1;
    localparam logic [1:0] OFF_CODE  = 2'd2;
    localparam logic [1:0] OFF_CMD   = 2'd3;
    localparam int CMD_GO    = 0;
    localparam int CMD_ABORT = 31;
    localparam int ST_BUSY   = 0;
    localparam int ST_ERR    = 1;
endpackage

// File: rtl/smem_wr_mux.sv
// smem_wr_mux: fixed-priority screen memory write port, CPU stores over engine writes
module smem_wr_mux #(
    parameter int AW = 11,
    parameter int DW = 4
) (
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_data,
    input  logic          eng_req,
    input  logic [AW-1:0] eng_addr,
    input  logic [DW-1:0] eng_data,
    output logic          we,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] wdata,
    output logic          eng_gnt
);
    always_comb begin
        eng_gnt = eng_req && !cpu_we;
        we      = cpu_we || eng_req;
        addr    = cpu_we ? cpu_addr : eng_addr;
        wdata   = cpu_we ? cpu_data : eng_data;
    end
endmodule

// File: rtl/smem_fill_ctrl.sv
// smem_fill_ctrl: memory-mapped screen fill engine sharing the smem write port with CPU stores
module smem_fill_ctrl
    import smem_fill_pkg::*;
#(
    parameter int          AW        = 11,
    parameter int          DW        = 4,
    parameter int          NLOC      = 1200,
    parameter logic [31:0] CTRL_BASE = 32'h0000_1000
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          mem_wr,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_writedata,
    output logic          smem_we,
    output logic [AW-1:0] smem_addr,
    output logic [DW-1:0] smem_wdata,
    output logic [31:0]   ctrl_readdata,
    output logic          busy,
    output logic          done
);
    state_t        state_q, state_d;
    logic [AW-1:0] start_q, start_d, idx_q, idx_d;
    logic [AW:0]   count_q, count_d, rem_q, rem_d;
    logic [DW-1:0] code_q, code_d, fcode_q, fcode_d;
    logic          err_q, err_d;
    logic          in_win, reg_wr, scr_wr, go, abort, eng_gnt, unused_bits;
    logic [1:0]    off;

    assign off         = mem_addr[3:2];
    assign in_win      = mem_addr[31:4] == CTRL_BASE[31:4];
    assign reg_wr      = mem_wr && in_win;
    assign scr_wr      = mem_wr && mem_addr[14];
    assign abort       = reg_wr && off == OFF_CMD && mem_writedata[CMD_ABORT];
    assign go          = reg_wr && off == OFF_CMD && mem_writedata[CMD_GO] && !mem_writedata[CMD_ABORT];
    assign busy        = state_q == FILL;
    assign done        = state_q == DONE;
    assign unused_bits = ^{mem_addr[1:0], mem_writedata[30:12]};

    always_comb begin
        ctrl_readdata = !in_win           ? 32'd0 :
                        off == OFF_START  ? 32'(start_q) :
                        off == OFF_COUNT  ? 32'(count_q) :
                        off == OFF_CODE   ? 32'(code_q) : 32'd0;
        if (in_win && off == OFF_CMD) begin
            ctrl_readdata[ST_BUSY] = busy;
            ctrl_readdata[ST_ERR]  = err_q;
        end
    end

    smem_wr_mux #(.AW(AW), .DW(DW)) u_mux (
        .cpu_we   (scr_wr),
        .cpu_addr (mem_addr[AW+1:2]),
        .cpu_data (mem_writedata[DW-1:0]),
        .eng_req  (busy),
        .eng_addr (idx_q),
        .eng_data (fcode_q),
        .we       (smem_we),
        .addr     (smem_addr),
        .wdata    (smem_wdata),
        .eng_gnt  (eng_gnt)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        fcode_d = fcode_q;
        err_d   = err_q;
        start_d = (reg_wr && off == OFF_START) ? mem_writedata[AW-1:0] : start_q;
        count_d = (reg_wr && off == OFF_COUNT) ? mem_writedata[AW:0]   : count_q;
        code_d  = (reg_wr && off == OFF_CODE)  ? mem_writedata[DW-1:0] : code_q;
        if (state_q == IDLE) begin
            if (go) begin
                if (count_q == '0) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                end else if (start_q >= AW'(NLOC)) begin
                    err_d = 1'b1;
                end else begin
                    state_d = FILL;
                    idx_d   = start_q;
                    rem_d   = count_q;
                    fcode_d = code_q;
                    err_d   = 1'b0;
                end
            end
        end else begin
            // GO is only honoured from IDLE; anything else flags a sticky error
            err_d = err_q || go;
            if (state_q == DONE || abort) begin
                state_d = IDLE;
            end else if (eng_gnt) begin
                idx_d   = (idx_q == AW'(NLOC - 1)) ? '0 : idx_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                state_d = (rem_q == (AW+1)'(1)) ? DONE : FILL;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            start_q <= '0;
            count_q <= '0;
            code_q  <= '0;
            idx_q   <= '0;
            rem_q   <= '0;
            fcode_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            count_q <= count_d;
            code_q  <= code_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            fcode_q <= fcode_d;
            err_q   <= err_d;
        end
    end
endmodule
